// File: rtl/mem_pkg.sv
// Shared types and constants for the memory access controller.
// Holds FSM state encoding, default widths and operation-type codes.
package mem_pkg;

  localparam int MEM_ADDR_W = 9;
  localparam int MEM_DATA_W = 32;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam logic MDR_SEL_BUS = 1'b0;
  localparam logic MDR_SEL_MEM = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_REQ = 2'd1,
    RD_CAP = 2'd2,
    WR_REQ = 2'd3
  } mem_state_e;

endpackage

// File: rtl/mdr_reg.sv
// Memory data register: loads from the datapath bus or RAM read data, 1-cycle.
// No backpressure; holds value whenever the load enable is low.
module mdr_reg
  import mem_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              sel_i,
  input  logic [DATA_W-1:0] bus_i,
  input  logic [DATA_W-1:0] mem_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] mdr_q;
  logic [DATA_W-1:0] mdr_d;

  always_comb begin
    mdr_d = mdr_q;
    if (en_i) begin
      mdr_d = (sel_i == MDR_SEL_MEM) ? mem_i : bus_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mdr_q <= '0;
    end else begin
      mdr_q <= mdr_d;
    end
  end

  assign q_o = mdr_q;

endmodule

// File: rtl/mem_ctrl.sv
// MAR/MDR holder and RAM strobe sequencer; read done 3 edges after start, write 2.
// Inputs are ignored while busy; a new start is accepted in the done cycle.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              mem_start,
  input  logic              mem_wr,
  input  logic [DATA_W-1:0] MDataIn,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [DATA_W-1:0] BusMuxInMDR,
  output logic              busy,
  output logic              done
);

  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic              done_q, done_d;
  logic              mdr_en;
  logic              mdr_sel;
  logic [DATA_W-1:0] mdr_val;

  // Only the low ADDR_W bits of the bus address the RAM.
  logic unused_bus_hi;
  assign unused_bus_hi = ^BusMuxOut[DATA_W-1:ADDR_W];

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    done_d  = 1'b0;
    mdr_en  = 1'b0;
    mdr_sel = MDR_SEL_BUS;
    case (state_q)
      IDLE: begin
        if (MARin) begin
          mar_d = BusMuxOut[ADDR_W-1:0];
        end
        mdr_en = MDRin;
        if (mem_start) begin
          state_d = (mem_wr == OP_WRITE) ? WR_REQ : RD_REQ;
        end
      end
      RD_REQ: state_d = RD_CAP;
      RD_CAP: begin
        // RAM output registered at the previous edge is valid now.
        mdr_en  = 1'b1;
        mdr_sel = MDR_SEL_MEM;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      WR_REQ: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mar_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      done_q  <= done_d;
    end
  end

  mdr_reg #(
    .DATA_W(DATA_W)
  ) u_mdr (
    .clk_i (clock),
    .rst_ni(reset_n),
    .en_i  (mdr_en),
    .sel_i (mdr_sel),
    .bus_i (BusMuxOut),
    .mem_i (MDataIn),
    .q_o   (mdr_val)
  );

  assign ram_read    = (state_q == RD_REQ);
  assign ram_write   = (state_q == WR_REQ);
  assign ram_addr    = mar_q;
  assign ram_wdata   = mdr_val;
  assign BusMuxInMDR = mdr_val;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory access controller sitting between the CPU datapath bus and the word-addressed synchronous RAM (512 × 32 bit, one-cycle registered read). Holds the MAR and MDR, sequences RAM read/write strobes, absorbs the RAM's read latency, captures read data into the MDR, and signals completion to the control unit with a one-cycle `done` pulse.

## Interface
- `ADDR_W`, 9, RAM word-address width
- `DATA_W`, 32, bus/data width

- `clock`  in  1  system clock, all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `BusMuxOut`  in  DATA_W  datapath bus value
- `MARin`  in  1  load MAR from `BusMuxOut[ADDR_W-1:0]`
- `MDRin`  in  1  load MDR from `BusMuxOut`
- `mem_start`  in  1  request a memory operation
- `mem_wr`  in  1  operation type sampled with `mem_start`: 1 write, 0 read
- `MDataIn`  in  DATA_W  RAM read data
- `ram_read`  out  1  RAM read strobe
- `ram_write`  out  1  RAM write strobe
- `ram_addr`  out  ADDR_W  RAM address (= MAR)
- `ram_wdata`  out  DATA_W  RAM write data (= MDR)
- `BusMuxInMDR`  out  DATA_W  MDR value to the bus mux
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  registered one-cycle completion pulse

## Operation
- States: IDLE, RD_REQ, RD_CAP, WR_REQ.
- IDLE: `MARin`/`MDRin` load at the edge; `mem_start` moves to RD_REQ (`mem_wr`=0) or WR_REQ (`mem_wr`=1).
- Same-edge loads and `mem_start` are legal; the operation uses the newly loaded MAR/MDR.
- RD_REQ: `ram_read`=1 → RD_CAP. RAM registers data at this edge.
- RD_CAP: `MDataIn` valid; MDR <= `MDataIn` → IDLE, `done`<=1.
- WR_REQ: `ram_write`=1 → IDLE, `done`<=1. RAM writes MDR to MAR at this edge.
- `ram_read`/`ram_write` are decoded from state only; they are never both high.
- While `busy`: `MARin`, `MDRin`, `mem_start` ignored; MAR/MDR stable.
- `ram_addr`, `ram_wdata`, `BusMuxInMDR` are continuously driven from the registers.
- No address wrap logic: all 2^ADDR_W addresses valid.

## Timing
- Reset: state IDLE; MAR=0, MDR=0; `done`=0, `busy`=0, `ram_read`=0, `ram_write`=0, `ram_addr`=0, `ram_wdata`=0, `BusMuxInMDR`=0.
- Reset mid-operation aborts immediately; strobes drop asynchronously; no `done`. RAM contents not reset; an in-flight write may or may not have landed.
- Read, start accepted at edge E0: `ram_read` in cycle E0–E1; MDR valid and `done`=1 in cycle E2–E3. Read latency is 3 edges.
- Write, start at E0: `ram_write` in cycle E0–E1; `done`=1 in cycle E1–E2.
- `done` is high for exactly one cycle, coincident with IDLE. A new `mem_start` is accepted in the `done` cycle (back-to-back).
- Throughput: one read per 2 cycles, one write per 1 cycle (plus IDLE accept cycle).

## Structure
- Shared package `mem_pkg`: state enum (2-bit encoding), `ADDR_W`/`DATA_W` defaults, `OP_READ`/`OP_WRITE` constants.
- One sub-module `mdr_reg`: DATA_W register with async active-low reset, 2:1 input mux (bus vs `MDataIn`), and load enable; the FSM drives its select and enable.
- MAR and FSM live in `mem_ctrl`.

## Test plan
- Reset with `reset_n`=0 mid-stream → all outputs 0, `busy`=0, and no strobe until a new start.
- `BusMuxOut`=0x0000_0155, `MARin`=1; then `BusMuxOut`=0xDEAD_BEEF, `MDRin`=1; `mem_start`=1, `mem_wr`=1 → `ram_write`=1 for one cycle with addr 0x155 and data 0xDEADBEEF; `done` on the next cycle.
- Read back 0x155 → `ram_read` one cycle; `BusMuxInMDR`=0xDEADBEEF together with `done`, 3 edges after start.
- `MARin`+`mem_start` (read) on the same edge with bus=0x0A0 → `ram_addr`=0x0A0 during RD_REQ, not the old MAR.
- `MDRin`=1 and `mem_start`=1 while `busy` → MDR unchanged and no extra operation; start asserted during `done` → new operation accepted back-to-back.
- Reset asserted during RD_REQ → `ram_read` drops immediately, no `done`, MDR=0; address 0x1FF write/read works (top address).
